poly_mau_lanes: RTL

//  Parametrised multi-lane modular arithmetic unit for the Kyber/Dilithium poly datapath.

---
 rtl/poly_mau_if.sv | 28 ++
 rtl/poly_mau.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/poly_mau_if.sv
// Beat-level handshake and lane data bundle for the poly modular arithmetic unit.
// The master side feeds operand beats and drains results; the slave side is the unit.
interface poly_mau_if #(
    parameter int W     = 24,
    parameter int LANES = 2
);
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         in_op;
    logic [LANES*W-1:0] in_a;
    logic [LANES*W-1:0] in_b;
    logic [LANES*W-1:0] in_w;
    logic               out_valid;
    logic               out_ready;
    logic [LANES*W-1:0] out_o0;
    logic [LANES*W-1:0] out_o1;
    logic [2:0]         out_op;

    modport master (
        output in_valid, in_op, in_a, in_b, in_w, out_ready,
        input  in_ready, out_valid, out_o0, out_o1, out_op
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_w, out_ready,
        output in_ready, out_valid, out_o0, out_o1, out_op
    );
endinterface

// File: rtl/poly_mau.sv
// Multi-lane modular add/sub/mul/CT/GS unit with a fixed-latency stallable pipeline.
// Stage 1 forms sums and the raw product, stage 2 Barrett-reduces, stage 3 finishes, rest is delay.
module poly_mau_lanes #(
    parameter int W     = 24,
    parameter int LANES = 2,
    parameter int LAT   = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic [W-1:0]   cfg_q,
    // Barrett constant floor(2^(2W)/q); needs 2W bits to be exact for every q
    input  logic [2*W-1:0] cfg_m,
    output logic           busy,
    poly_mau_if.slave      bus
);
    localparam int N = LAT - 2;
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_CT  = 3'd3;
    localparam logic [2:0] OP_GS  = 3'd4;

    function automatic logic [W-1:0] add_mod(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] q);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, q}) s = s - {1'b0, q};
        else                s = s;
        return W'(s);
    endfunction

    function automatic logic [W-1:0] sub_mod(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] q);
        logic [W:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[W]) d = d + {1'b0, q};
        else      d = d;
        return W'(d);
    endfunction

    // Quotient estimate undershoots by at most 2, so the remainder lies in [0, 3q)
    function automatic logic [W+1:0] barrett_r(input logic [2*W-1:0] x, input logic [2*W-1:0] m,
                                               input logic [W-1:0] q);
        logic [4*W-1:0] xm;
        logic [W-1:0]   qh;
        logic [2*W-1:0] qq;
        xm = {{(2*W){1'b0}}, x} * {{(2*W){1'b0}}, m};
        qh = W'(xm >> (2*W));
        qq = {{W{1'b0}}, qh} * {{W{1'b0}}, q};
        return (W+2)'(x - qq);
    endfunction

    function automatic logic [W-1:0] fold(input logic [W+1:0] r, input logic [W-1:0] q);
        logic [W+1:0] v;
        v = r;
        if (v >= {2'b00, q}) v = v - {2'b00, q};
        else                 v = v;
        if (v >= {2'b00, q}) v = v - {2'b00, q};
        else                 v = v;
        return W'(v);
    endfunction

    logic       stall_s, advance_s;
    logic       v1_r, v2_r;
    logic [2:0] op1_r, op2_r;
    logic       vld_r [N];
    logic [2:0] op_r  [N];
    logic [W-1:0] lane_o0 [LANES];
    logic [W-1:0] lane_o1 [LANES];

    assign stall_s      = vld_r[N-1] && !bus.out_ready;
    assign advance_s    = !stall_s;
    assign bus.in_ready = !stall_s;
    assign bus.out_valid = vld_r[N-1];
    assign bus.out_op    = op_r[N-1];

    // Stage valids and op codes; clr wins over stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r <= 1'b0; v2_r <= 1'b0; op1_r <= 3'd0; op2_r <= 3'd0;
            for (int k = 0; k < N; k++) begin
                vld_r[k] <= 1'b0;
                op_r[k]  <= 3'd0;
            end
        end else if (clr) begin
            v1_r <= 1'b0; v2_r <= 1'b0;
            for (int k = 0; k < N; k++) vld_r[k] <= 1'b0;
        end else if (advance_s) begin
            v1_r <= bus.in_valid; op1_r <= bus.in_op;
            v2_r <= v1_r;         op2_r <= op1_r;
            vld_r[0] <= v2_r;     op_r[0] <= op2_r;
            for (int k = 1; k < N; k++) begin
                vld_r[k] <= vld_r[k-1];
                op_r[k]  <= op_r[k-1];
            end
        end
    end

    // Busy whenever any stage holds a beat
    always_comb begin
        busy = v1_r | v2_r;
        for (int k = 0; k < N; k++) busy = busy | vld_r[k];
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [W-1:0]   a_s, b_s, w_s, mx_s, my_s, r0_s, r1_s, t_s, o0_s, o1_s;
        logic [W-1:0]   a1_r, r01_r, r11_r, a2_r, r02_r, r12_r;
        logic [2*W-1:0] x1_r;
        logic [W+1:0]   p2_r;
        logic [W-1:0]   o0_r [N];
        logic [W-1:0]   o1_r [N];

        assign a_s = bus.in_a[g*W +: W];
        assign b_s = bus.in_b[g*W +: W];
        assign w_s = bus.in_w[g*W +: W];

        // Operand steering: GS multiplies the reduced difference by the twiddle
        always_comb begin
            r0_s = a_s; r1_s = {W{1'b0}}; mx_s = {W{1'b0}}; my_s = {W{1'b0}};
            case (bus.in_op)
                OP_ADD:  r0_s = add_mod(a_s, b_s, cfg_q);
                OP_SUB:  r0_s = sub_mod(a_s, b_s, cfg_q);
                OP_MUL:  begin mx_s = a_s; my_s = b_s; end
                OP_CT:   begin mx_s = b_s; my_s = w_s; end
                OP_GS:   begin r0_s = add_mod(a_s, b_s, cfg_q); mx_s = sub_mod(a_s, b_s, cfg_q); my_s = w_s; end
                default: r1_s = b_s;
            endcase
        end

        // Final stage: butterfly add/sub around the reduced product
        always_comb begin
            t_s  = fold(p2_r, cfg_q);
            o0_s = r02_r;
            o1_s = r12_r;
            case (op2_r)
                OP_MUL:  o0_s = t_s;
                OP_CT:   begin o0_s = add_mod(a2_r, t_s, cfg_q); o1_s = sub_mod(a2_r, t_s, cfg_q); end
                OP_GS:   o1_s = t_s;
                default: o0_s = r02_r;
            endcase
        end

        // Lane data registers; data moves with the valids, clr needs no data action
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a1_r <= {W{1'b0}}; r01_r <= {W{1'b0}}; r11_r <= {W{1'b0}}; x1_r <= {(2*W){1'b0}};
                a2_r <= {W{1'b0}}; r02_r <= {W{1'b0}}; r12_r <= {W{1'b0}}; p2_r <= {(W+2){1'b0}};
                for (int k = 0; k < N; k++) begin
                    o0_r[k] <= {W{1'b0}};
                    o1_r[k] <= {W{1'b0}};
                end
            end else if (advance_s) begin
                a1_r <= a_s; r01_r <= r0_s; r11_r <= r1_s;
                x1_r <= {{W{1'b0}}, mx_s} * {{W{1'b0}}, my_s};
                a2_r <= a1_r; r02_r <= r01_r; r12_r <= r11_r;
                p2_r <= barrett_r(x1_r, cfg_m, cfg_q);
                o0_r[0] <= o0_s;
                o1_r[0] <= o1_s;
                for (int k = 1; k < N; k++) begin
                    o0_r[k] <= o0_r[k-1];
                    o1_r[k] <= o1_r[k-1];
                end
            end
        end

        assign lane_o0[g] = o0_r[N-1];
        assign lane_o1[g] = o1_r[N-1];
    end

    // Pack lane results onto the output bus
    always_comb begin
        bus.out_o0 = {(LANES*W){1'b0}};
        bus.out_o1 = {(LANES*W){1'b0}};
        for (int i = 0; i < LANES; i++) begin
            bus.out_o0[i*W +: W] = lane_o0[i];
            bus.out_o1[i*W +: W] = lane_o1[i];
        end
    end
endmodule
